// File: rtl/lisnoc_router_input_vc.sv
// Router input port: per-VC FIFO, wormhole route FSM and a registered out stage per VC.
// Optional LISNOC_INPUT_BYPASS_EN lets a flit skip an empty FIFO straight into the out stage.
module lisnoc_router_input_vc #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 2,
  parameter int ports           = 5,
  parameter int fifo_length     = 4,
  parameter int num_dests       = 1,
  parameter int dest_width      = 5,
  parameter logic [ports*num_dests-1:0] lookup = '0
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [flit_data_width+flit_type_width-1:0]             link_flit,
  input  logic [vchannels-1:0]                                   link_valid,
  output logic [vchannels-1:0]                                   link_ready,
  output logic [ports*vchannels-1:0]                             switch_request,
  output logic [(flit_data_width+flit_type_width)*vchannels-1:0] switch_flit,
  input  logic [ports*vchannels-1:0]                             switch_read,
  output logic [vchannels-1:0]                                   proto_err
);

  localparam int FW = flit_data_width + flit_type_width;
  localparam int PW = $clog2(fifo_length);
  localparam int CW = $clog2(fifo_length + 1);

  localparam logic [flit_type_width-1:0] T_PAYLOAD = flit_type_width'(0);
  localparam logic [flit_type_width-1:0] T_HEADER  = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] T_LAST    = flit_type_width'(2);
  localparam logic [flit_type_width-1:0] T_SINGLE  = flit_type_width'(3);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  for (genvar gi = 0; gi < vchannels; gi++) begin : g_vc
    logic [FW-1:0]              mem_q [fifo_length];
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;
    state_t                     state_q, state_d;
    logic [ports-1:0]           dir_q, dir_d;
    logic                       out_valid_q;
    logic [FW-1:0]              out_flit_q;
    logic [ports-1:0]           out_dir_q;
    logic                       err_q;

    logic                       push, fifo_push, fifo_pop, fifo_nonempty;
    logic                       consume, out_free, bypass_sel;
    logic                       cand_valid;
    logic [FW-1:0]              cand_flit;
    logic [flit_type_width-1:0] cand_type;
    logic [dest_width-1:0]      cand_dest;
    logic                       route_ok;
    logic [ports-1:0]           route_dir, load_dir;
    logic                       take, load, err;

    assign fifo_nonempty = (count_q != '0);
    assign link_ready[gi] = (count_q < CW'(fifo_length)) && !rst;
    assign push     = link_valid[gi] & link_ready[gi];
    assign consume  = out_valid_q & (|switch_read[gi*ports +: ports]);
    assign out_free = !out_valid_q | consume;

`ifdef LISNOC_INPUT_BYPASS_EN
    assign bypass_sel = push & !fifo_nonempty & out_free;
`else
    assign bypass_sel = 1'b0;
`endif

    assign cand_valid = fifo_nonempty | bypass_sel;
    assign cand_flit  = fifo_nonempty ? mem_q[rd_ptr_q] : link_flit;
    assign cand_type  = cand_flit[FW-1 -: flit_type_width];
    assign cand_dest  = cand_flit[flit_data_width-1 -: dest_width];

    // Destination 0 sits in the most significant slice of the lookup table.
    always_comb begin
      route_ok  = 1'b0;
      route_dir = '0;
      for (int d = 0; d < num_dests; d++) begin
        if (cand_dest == dest_width'(d)) begin
          route_ok  = 1'b1;
          route_dir = lookup[(num_dests-1-d)*ports +: ports];
        end
      end
    end

    always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      load_dir = dir_q;
      take     = 1'b0;
      load     = 1'b0;
      err      = 1'b0;
      if (cand_valid) begin
        case (state_q)
          IDLE: begin
            if (cand_type == T_HEADER || cand_type == T_SINGLE) begin
              if (!route_ok) begin
                take = 1'b1;
                err  = 1'b1;
                if (cand_type == T_HEADER) state_d = DROP;
              end else if (out_free) begin
                take     = 1'b1;
                load     = 1'b1;
                load_dir = route_dir;
                if (cand_type == T_HEADER) begin
                  state_d = ACTIVE;
                  dir_d   = route_dir;
                end
              end
            end else begin
              // Stray PAYLOAD/LAST with no open packet.
              take = 1'b1;
              err  = 1'b1;
            end
          end
          ACTIVE: begin
            if (out_free) begin
              take = 1'b1;
              load = 1'b1;
              if (cand_type == T_LAST) state_d = IDLE;
            end
          end
          DROP: begin
            take = 1'b1;
            if (cand_type == T_LAST) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    assign fifo_push = push & !bypass_sel;
    assign fifo_pop  = take & fifo_nonempty;

    always_ff @(posedge clk) begin
      if (fifo_push) mem_q[wr_ptr_q] <= link_flit;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        state_q     <= IDLE;
        dir_q       <= '0;
        out_valid_q <= 1'b0;
        out_flit_q  <= '0;
        out_dir_q   <= '0;
        err_q       <= 1'b0;
      end else begin
        if (fifo_push) wr_ptr_q <= (wr_ptr_q == PW'(fifo_length-1)) ? '0 : wr_ptr_q + 1'b1;
        if (fifo_pop)  rd_ptr_q <= (rd_ptr_q == PW'(fifo_length-1)) ? '0 : rd_ptr_q + 1'b1;
        case ({fifo_push, fifo_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        state_q <= state_d;
        dir_q   <= dir_d;
        if (load) begin
          out_valid_q <= 1'b1;
          out_flit_q  <= cand_flit;
          out_dir_q   <= load_dir;
        end else if (consume) begin
          out_valid_q <= 1'b0;
        end
        err_q <= err;
      end
    end

    assign switch_request[gi*ports +: ports] = out_valid_q ? out_dir_q : '0;
    assign switch_flit[gi*FW +: FW]          = out_flit_q;
    assign proto_err[gi]                     = err_q;
  end

endmodule

// File: tb/tb_lisnoc_router_input_vc.sv
// Directed bench for lisnoc_router_input_vc: two instances (fifo_length 4 and 3), two destinations.
module tb_lisnoc_router_input_vc;

  localparam int FW = 34;
  localparam logic [9:0] LOOKUP = 10'b00010_01000;
`ifdef LISNOC_INPUT_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [1:0] PAY = 2'b00, HDR = 2'b01, LST = 2'b10, SGL = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [FW-1:0] link_flit, b_link_flit;
  logic [1:0]    link_valid, link_ready, proto_err;
  logic [1:0]    b_link_valid, b_link_ready, b_proto_err;
  logic [9:0]    switch_request, switch_read, rd_mask;
  logic [9:0]    b_switch_request, b_switch_read, b_rd_mask;
  logic [67:0]   switch_flit, b_switch_flit;

  assign switch_read   = switch_request & rd_mask;
  assign b_switch_read = b_switch_request & b_rd_mask;

  lisnoc_router_input_vc #(
    .flit_data_width(32), .flit_type_width(2), .vchannels(2), .ports(5),
    .fifo_length(4), .num_dests(2), .dest_width(5), .lookup(LOOKUP)
  ) u_dut (
    .clk(clk), .rst(rst), .link_flit(link_flit), .link_valid(link_valid),
    .link_ready(link_ready), .switch_request(switch_request), .switch_flit(switch_flit),
    .switch_read(switch_read), .proto_err(proto_err)
  );

  lisnoc_router_input_vc #(
    .flit_data_width(32), .flit_type_width(2), .vchannels(2), .ports(5),
    .fifo_length(3), .num_dests(2), .dest_width(5), .lookup(LOOKUP)
  ) u_dut_b (
    .clk(clk), .rst(rst), .link_flit(b_link_flit), .link_valid(b_link_valid),
    .link_ready(b_link_ready), .switch_request(b_switch_request), .switch_flit(b_switch_flit),
    .switch_read(b_switch_read), .proto_err(b_proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [4:0] d, input logic [26:0] p);
    return {t, d, p};
  endfunction

  logic [FW-1:0] seq0 [10];
  logic [FW-1:0] seq1 [10];
  logic [FW-1:0] got_q [$];
  int err_cnt, err1_cnt, req_cnt, sent;
  logic [4:0] req_dir;
  logic [FW-1:0] req_flit;

  initial begin
    rst = 1'b1; link_valid = '0; link_flit = '0; rd_mask = '1;
    b_link_valid = '0; b_link_flit = '0; b_rd_mask = '1;
    tick(); tick();
    check("rst_link_ready", 64'(link_ready), 64'(2'b00));
    check("rst_switch_request", 64'(switch_request), 64'(10'b0));
    check("rst_proto_err", 64'(proto_err), 64'(2'b00));
    rst = 1'b0;
    tick();
    check("link_ready_after_rst", 64'(link_ready), 64'(2'b11));

    // 1: basic packet on VC0 with echoed reads
    seq0[0] = mk(HDR, 5'd0, 27'h11); seq0[1] = mk(PAY, 5'd0, 27'h12); seq0[2] = mk(LST, 5'd0, 27'h13);
    for (int j = 1; j <= 6; j++) begin
      if (j <= 3) begin link_valid = 2'b01; link_flit = seq0[j-1]; end
      else link_valid = 2'b00;
      tick();
      if (j >= LAT && j < LAT + 3) begin
        check($sformatf("t1_req_e%0d", j), 64'(switch_request[4:0]), 64'(5'b00010));
        check($sformatf("t1_flit_e%0d", j), 64'(switch_flit[33:0]), 64'(seq0[j-LAT]));
      end else begin
        check($sformatf("t1_req_e%0d", j), 64'(switch_request[4:0]), 64'(5'b0));
      end
      check($sformatf("t1_err_e%0d", j), 64'(proto_err), 64'(2'b00));
    end

    // 2: backpressure on VC1 with no reads
    rd_mask = 10'b00000_11111;
    seq1[0] = mk(HDR, 5'd1, 27'h21); seq1[1] = mk(PAY, 5'd1, 27'h22); seq1[2] = mk(PAY, 5'd1, 27'h23);
    seq1[3] = mk(PAY, 5'd1, 27'h24); seq1[4] = mk(PAY, 5'd1, 27'h25); seq1[5] = mk(LST, 5'd1, 27'h26);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_ready_%0d", i), 64'(link_ready[1]), 64'(1'b1));
      link_valid = 2'b10; link_flit = seq1[i];
      tick();
    end
    link_valid = 2'b00;
    check("t2_ready_full", 64'(link_ready[1]), 64'(1'b0));
    check("t2_req_held", 64'(switch_request[9:5]), 64'(5'b01000));
    check("t2_flit_held", 64'(switch_flit[67:34]), 64'(seq1[0]));
    rd_mask = '1;
    tick();
    rd_mask = 10'b00000_11111;
    check("t2_ready_restored", 64'(link_ready[1]), 64'(1'b1));
    check("t2_flit_after_read", 64'(switch_flit[67:34]), 64'(seq1[1]));
    link_valid = 2'b10; link_flit = seq1[5];
    tick();
    link_valid = 2'b00; rd_mask = '1;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("t2_drain_req_%0d", j), 64'(switch_request[9:5]), 64'(5'b01000));
      check($sformatf("t2_drain_flit_%0d", j), 64'(switch_flit[67:34]), 64'(seq1[j+1]));
      tick();
    end
    check("t2_drain_empty", 64'(switch_request[9:5]), 64'(5'b0));

    // 3: stray payload, unroutable packet, then a valid single
    seq0[0] = mk(PAY, 5'd0, 27'h31); seq0[1] = mk(HDR, 5'd2, 27'h32); seq0[2] = mk(PAY, 5'd0, 27'h33);
    seq0[3] = mk(PAY, 5'd0, 27'h34); seq0[4] = mk(LST, 5'd0, 27'h35); seq0[5] = mk(SGL, 5'd0, 27'h36);
    err_cnt = 0; err1_cnt = 0; req_cnt = 0; req_dir = '0; req_flit = '0;
    for (int c = 0; c < 14; c++) begin
      if (c < 6) begin link_valid = 2'b01; link_flit = seq0[c]; end
      else link_valid = 2'b00;
      tick();
      if (proto_err[0]) err_cnt++;
      if (proto_err[1]) err1_cnt++;
      if (switch_request[4:0] != 5'b0) begin
        req_cnt++; req_dir = switch_request[4:0]; req_flit = switch_flit[33:0];
      end
    end
    check("t3_err_pulses", 64'(err_cnt), 64'(2));
    check("t3_err_vc1", 64'(err1_cnt), 64'(0));
    check("t3_req_count", 64'(req_cnt), 64'(1));
    check("t3_req_dir", 64'(req_dir), 64'(5'b00010));
    check("t3_req_flit", 64'(req_flit), 64'(seq0[5]));

    // 4: VC0 stalled while VC1 streams
    rd_mask = 10'b11111_00000;
    seq0[0] = mk(HDR, 5'd0, 27'h41); seq0[1] = mk(PAY, 5'd0, 27'h42); seq0[2] = mk(LST, 5'd0, 27'h43);
    seq1[0] = mk(HDR, 5'd1, 27'h51); seq1[1] = mk(PAY, 5'd1, 27'h52);
    seq1[2] = mk(PAY, 5'd1, 27'h53); seq1[3] = mk(LST, 5'd1, 27'h54);
    for (int e = 1; e <= 10; e++) begin
      if (e - 1 < 3) begin link_valid = 2'b01; link_flit = seq0[e-1]; end
      else if (e - 1 < 7) begin link_valid = 2'b10; link_flit = seq1[e-4]; end
      else link_valid = 2'b00;
      tick();
      if (e >= LAT) begin
        check($sformatf("t4_vc0_req_e%0d", e), 64'(switch_request[4:0]), 64'(5'b00010));
        check($sformatf("t4_vc0_flit_e%0d", e), 64'(switch_flit[33:0]), 64'(seq0[0]));
      end
      if (e - 3 - LAT >= 0 && e - 3 - LAT < 4) begin
        check($sformatf("t4_vc1_req_e%0d", e), 64'(switch_request[9:5]), 64'(5'b01000));
        check($sformatf("t4_vc1_flit_e%0d", e), 64'(switch_flit[67:34]), 64'(seq1[e-3-LAT]));
      end else begin
        check($sformatf("t4_vc1_req_e%0d", e), 64'(switch_request[9:5]), 64'(5'b0));
      end
    end
    rd_mask = '1;
    tick();
    check("t4_vc0_release_1", 64'(switch_flit[33:0]), 64'(seq0[1]));
    tick();
    check("t4_vc0_release_2", 64'(switch_flit[33:0]), 64'(seq0[2]));
    tick();
    check("t4_vc0_empty", 64'(switch_request[4:0]), 64'(5'b0));

    // 5: reset mid-packet
    link_valid = 2'b01; link_flit = mk(HDR, 5'd0, 27'h61);
    tick();
    link_flit = mk(PAY, 5'd0, 27'h62);
    tick();
    link_valid = 2'b00; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_req_after_rst", 64'(switch_request), 64'(10'b0));
    check("t5_err_after_rst", 64'(proto_err), 64'(2'b00));
    seq0[0] = mk(LST, 5'd0, 27'h63); seq0[1] = mk(SGL, 5'd1, 27'h64);
    err_cnt = 0; req_cnt = 0; req_dir = '0; req_flit = '0;
    for (int c = 0; c < 10; c++) begin
      if (c < 2) begin link_valid = 2'b01; link_flit = seq0[c]; end
      else link_valid = 2'b00;
      tick();
      if (proto_err[0]) err_cnt++;
      if (switch_request[4:0] != 5'b0) begin
        req_cnt++; req_dir = switch_request[4:0]; req_flit = switch_flit[33:0];
      end
    end
    check("t5_err_pulses", 64'(err_cnt), 64'(1));
    check("t5_req_count", 64'(req_cnt), 64'(1));
    check("t5_req_dir", 64'(req_dir), 64'(5'b01000));
    check("t5_req_flit", 64'(req_flit), 64'(seq0[1]));

    // 6: FIFO wrap on the 3-deep instance with random read stalls
    for (int i = 0; i < 10; i++) seq0[i] = mk(SGL, 5'd0, 27'(32'h700 + i));
    sent = 0;
    for (int cyc = 0; cyc < 300 && got_q.size() < 10; cyc++) begin
      if (sent < 10 && b_link_ready[0]) begin
        b_link_valid = 2'b01; b_link_flit = seq0[sent]; sent++;
      end else b_link_valid = 2'b00;
      b_rd_mask = ($urandom_range(0, 3) != 0) ? 10'h3ff : 10'h000;
      #0;
      if (b_switch_request[4:0] != 5'b0 && b_rd_mask[0]) got_q.push_back(b_switch_flit[33:0]);
      tick();
    end
    b_link_valid = 2'b00;
    check("t6_count", 64'(got_q.size()), 64'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < got_q.size()) check($sformatf("t6_flit_%0d", i), 64'(got_q[i]), 64'(seq0[i]));
      else check($sformatf("t6_flit_%0d", i), 64'hdead, 64'(seq0[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
